// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: raster scan controller that fetches each pixel colour from the
// graphics stage and hands it to the LT24 driver with a pixelWrite/pixelReady handshake.
module pixel_scan_ctrl #(
    parameter int LCD_WIDTH   = 240,
    parameter int LCD_HEIGHT  = 320,
    parameter int GFX_LATENCY = 1,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        enable,
    input  logic        pixelReady,
    input  logic [15:0] gfx_rgb,
    output logic [7:0]  x_addr,
    output logic [8:0]  y_addr,
    output logic        pixelWrite,
    output logic [15:0] pixelData,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);
    localparam logic [7:0]  X_END   = 8'(LCD_WIDTH - 1);
    localparam logic [8:0]  Y_END   = 9'(LCD_HEIGHT - 1);
    localparam logic [15:0] LAT_END = 16'(GFX_LATENCY - 1);
    localparam logic [15:0] GAP_END = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, GAP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  x_n;
    logic [8:0]  y_n;
    logic        wr_n, fs_n, fd_n;
    logic [15:0] data_n, fc_n;
    logic        last_col, last_pix;

    assign last_col = x_addr == X_END;
    assign last_pix = last_col && y_addr == Y_END;

    // cnt counts graphics latency in FETCH and idle cycles in GAP
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = x_addr;
        y_n     = y_addr;
        wr_n    = pixelWrite;
        data_n  = pixelData;
        fs_n    = 1'b0;
        fd_n    = 1'b0;
        fc_n    = frame_count;
        case (state)
            IDLE: if (enable) begin
                state_n = FETCH;
                cnt_n   = '0;
                x_n     = '0;
                y_n     = '0;
                fs_n    = 1'b1;
            end
            FETCH: if (cnt == LAT_END) begin
                state_n = WRITE;
                data_n  = gfx_rgb;
                wr_n    = 1'b1;
            end else cnt_n = cnt + 16'd1;
            WRITE: if (pixelReady) begin
                wr_n    = 1'b0;
                cnt_n   = '0;
                x_n     = last_col ? '0 : x_addr + 8'd1;
                y_n     = last_pix ? '0 : last_col ? y_addr + 9'd1 : y_addr;
                fd_n    = last_pix;
                fc_n    = last_pix ? frame_count + 16'd1 : frame_count;
                state_n = last_pix ? GAP : FETCH;
            end
            GAP: if (cnt == GAP_END) begin
                state_n = enable ? FETCH : IDLE;
                cnt_n   = '0;
                fs_n    = enable;
            end else cnt_n = cnt + 16'd1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state       <= IDLE;
            cnt         <= '0;
            x_addr      <= '0;
            y_addr      <= '0;
            pixelWrite  <= 1'b0;
            pixelData   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            x_addr      <= x_n;
            y_addr      <= y_n;
            pixelWrite  <= wr_n;
            pixelData   <= data_n;
            frame_start <= fs_n;
            frame_done  <= fd_n;
            frame_count <= fc_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule
